wide_add_seq: RTL and testbench
===============================

# wide_add_seq

Multi-cycle N-byte adder/subtractor controller. It accepts one wide operand pair through a valid/ready handshake and sequences it through a single 8-bit adder slice, one byte per cycle, least-significant byte first. The block registers the inter-byte carry and assembles the result, then presents sum, carry and signed overflow through a valid/ready output handshake. It sits between the register/ALU front end and the shared 8-bit adder datapath, so wide arithmetic never needs a full-width adder.

## Interface
- NBYTES, 4, operand width in bytes (legal 2..16); W = 8*NBYTES.
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and op are valid.
- in_ready  output  1  block can accept an operation.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- a  input  W  operand A, unsigned/two's complement.
- b  input  W  operand B.
- out_valid  output  1  result registers hold a new result.
- out_ready  input  1  consumer accepts the result.
- s  output  W  result.
- cout  output  1  final carry out; for subtract, 1 = no borrow.
- ovf  output  1  signed (two's complement) overflow.
- busy  output  1  operation in progress (state RUN).

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE; s=0, cout=0, ovf=0, out_valid=0, busy=0, byte counter=0, carry register=0.
- in_ready = (state==IDLE) && !rst. in_valid is ignored while rst is high or outside IDLE.
- IDLE: on in_valid&&in_ready, latch a, op, and b_eff = op ? ~b : b. Carry register <= op. Counter <= 0. Go to RUN.
- RUN: each cycle add byte i of a, byte i of b_eff and the carry register in the 8-bit slice. Write the sum into byte i of s; carry register <= slice carry out; counter++.
- RUN, last byte (counter==NBYTES-1):
  - cout <= slice carry out.
  - ovf <= (a[W-1]==b_eff[W-1]) && (sum[7] != a[W-1]).
  - Go to DONE.
- s bytes not yet written during RUN are not defined and are not observable, because out_valid=0.
- DONE: out_valid=1. s, cout and ovf are held stable. On out_ready go to IDLE; out_valid drops the next cycle.
- Result registers hold the last result in IDLE until the next operation overwrites them. They are not cleared on accept.
- busy = (state==RUN).
- Input operands are captured at acceptance. Changes on a, b or op after the accept edge have no effect.
- Arithmetic is modulo 2^W. There is no saturation.

## Timing
- Accept at edge k. Bytes are processed on edges k+1 .. k+NBYTES. out_valid is high from the cycle after edge k+NBYTES.
- Latency from accept edge to out_valid is NBYTES cycles.
- Output accepted at edge m (out_valid&&out_ready): state is IDLE after m and in_ready is high in the next cycle. The earliest next accept is edge m+1.
- Throughput is one operation per NBYTES+2 cycles when out_ready is held high.
- in_ready is combinational from state and rst. All other outputs are registered.
- Reset asserted in any state takes effect at the next edge and overrides handshakes in the same cycle. Any in-flight operation is discarded and no out_valid is produced for it.
- out_ready with out_valid=0 has no effect.

## Test plan
- NBYTES=4, add 0xFFFFFFFF + 0x00000001 -> out_valid exactly 4 cycles after accept; s=0x00000000, cout=1, ovf=0; busy high for 4 cycles.
- Add 0x7FFFFFFF + 0x00000001 -> s=0x80000000, cout=0, ovf=1. Sub 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, cout=1, ovf=1.
- Sub 0x00000005 - 0x00000007 -> s=0xFFFFFFFE, cout=0 (borrow), ovf=0. Sub 0x12345678 - 0x12345678 -> s=0, cout=1, ovf=0.
- Backpressure: out_ready held low for 5 cycles in DONE -> out_valid, s, cout and ovf stay stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready -> out_valid drops the next cycle and in_ready rises.
- Reset mid-RUN: accept 0x11111111+0x22222222, assert rst for 1 cycle at the second RUN cycle -> all outputs 0, state IDLE, and no out_valid follows. A new add 0x00000001+0x00000002 after reset gives s=0x00000003.
- Back-to-back: 3 random add/sub operations with in_valid and out_ready held high -> each result matches a reference model modulo 2^32 with correct cout/ovf, and accept edges are spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/wide_add_seq.sv
// wide_add_seq: wide adder/subtractor that runs one operand pair through a
// single 8-bit adder slice, least-significant byte first.
//
// Operands are captured at acceptance. During RUN, the operand registers
// shift right one byte per cycle, so the slice always sees the current byte
// in bits [7:0]. The result register shifts in each slice sum from the top.
// After NBYTES shifts, the whole result sits in place. On the last byte, the
// operand top bits are in [7], which is where the signed overflow test
// reads them.
module wide_add_seq #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);

    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [8:0]    slice;
    logic          last;
    logic          accept;

    // One byte of the shared adder: {carry_out, sum}.
    function automatic logic [8:0] add_slice(input logic [7:0] x,
                                             input logic [7:0] y,
                                             input logic       ci);
        return {1'b0, x} + {1'b0, y} + {8'd0, ci};
    endfunction

    // Two's complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic sa,
                                        input logic sb,
                                        input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign slice    = add_slice(a_sh[7:0], b_sh[7:0], carry);
    assign last     = (cnt == LAST);
    assign in_ready = (state == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Sequencer: state, byte counter, inter-byte carry and handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        carry <= op;
                    end
                end
                ST_RUN: begin
                    carry <= slice[8];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

    // Operand capture at accept (B inverted for subtract), then a byte shift per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= op ? ~b : b;
        end else if (state == ST_RUN) begin
            a_sh <= {8'd0, a_sh[W-1:8]};
            b_sh <= {8'd0, b_sh[W-1:8]};
        end
    end

    // Result assembly: sums shift in from the top; flags are taken on the last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == ST_RUN) begin
            s <= {slice[7:0], s[W-1:8]};
            if (last) begin
                cout <= slice[8];
                ovf  <= signed_ovf(a_sh[7], b_sh[7], slice[7]);
            end
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed testbench for wide_add_seq with NBYTES=4.
module tb_wide_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n;
    int acc [3];
    logic        stray;
    logic [31:0] xa, xb;
    logic        xo;
    logic [33:0] exp_r;

    wide_add_seq #(.NBYTES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width add of a and b or ~b plus op. Returns {ovf, cout, s}.
    function automatic logic [33:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] be;
        logic [32:0] r;
        be = o ? ~y : y;
        r  = {1'b0, x} + {1'b0, be} + {32'd0, o};
        return {(x[31] == be[31]) && (r[31] != x[31]), r[32], r[31:0]};
    endfunction

    // Accept one operation, then check busy/out_valid for exactly 4 cycles of latency.
    task automatic run_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] es, input logic ec, input logic eo);
        check({tag, " in_ready"}, in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        a = ~x; b = ~y; op = ~o;
        for (int i = 1; i < 4; i++) begin
            check({tag, " run {ov,busy}"}, {out_valid, busy}, 2'b01);
            tick;
        end
        check({tag, " last {ov,busy}"}, {out_valid, busy}, 2'b01);
        tick;
        check({tag, " done {ov,busy}"}, {out_valid, busy}, 2'b10);
        check({tag, " s"}, s, es);
        check({tag, " {cout,ovf}"}, {cout, ovf}, {ec, eo});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, " release out_valid"}, out_valid, 0);
        check({tag, " release in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
        tick;
        tick;
        check("reset in_ready", in_ready, 0);
        check("reset outputs", {out_valid, busy, cout, ovf, s}, 36'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1);

        run_op("add ffffffff+1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        release_out("add ffffffff+1");
        run_op("add 7fffffff+1", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        release_out("add 7fffffff+1");
        run_op("sub 80000000-1", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        release_out("sub 80000000-1");
        run_op("sub 5-7", 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        release_out("sub 5-7");
        run_op("sub equal", 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
        release_out("sub equal");

        // Backpressure: result held for 5 cycles, in_valid pulses ignored.
        run_op("bp add", 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 32'hAAAA_0000 + i; b = 32'h5555_0000; op = 1'b0;
            tick;
            check("bp hold", {out_valid, in_ready, busy, cout, ovf, s}, {5'b10000, 32'h2345_6789});
        end
        in_valid = 1'b0;
        release_out("bp");

        // Reset during the second RUN cycle discards the operation.
        op = 1'b0; a = 32'h1111_1111; b = 32'h2222_2222; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        check("mid-run rst in_ready", in_ready, 0);
        tick;
        rst = 1'b0;
        #1;
        check("mid-run rst outputs", {out_valid, busy, cout, ovf, s}, 36'd0);
        check("mid-run rst in_ready after", in_ready, 1);
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            stray = stray | out_valid | busy;
        end
        check("mid-run rst no stray result", stray, 0);
        run_op("add 1+2 after rst", 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
        release_out("add 1+2 after rst");

        // Back-to-back with in_valid and out_ready held high.
        void'($urandom(32'h5eed));
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            xa = $urandom;
            xb = $urandom;
            xo = 1'($urandom_range(0, 1));
            exp_r = model(xo, xa, xb);
            a = xa; b = xb; op = xo;
            n = 0;
            while (!in_ready && n < 20) begin
                tick;
                n++;
            end
            check("b2b in_ready wait", in_ready, 1);
            tick;
            acc[j] = cyc;
            a = ~xa; b = ~xb; op = ~xo;
            if (j > 0) check("b2b accept spacing", 64'(acc[j] - acc[j-1]), 64'd6);
            n = 0;
            while (!out_valid && n < 20) begin
                tick;
                n++;
            end
            if (j == 2) in_valid = 1'b0;
            check("b2b out_valid", out_valid, 1);
            check("b2b s", s, exp_r[31:0]);
            check("b2b {cout,ovf}", {cout, ovf}, {exp_r[32], exp_r[33]});
        end
        tick;
        out_ready = 1'b0;
        check("b2b drained", {out_valid, busy}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
